// File: rtl/hilo_mdu_if.sv
// EX-stage bundle between the pipeline and the HI/LO multiply unit.
// The control-code values are normally supplied by the shared ALU defines
// header; the guarded fallbacks below keep this file usable on its own.
`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b10000
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b10001
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'b10010
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'b10011
`endif
`ifndef MFHI_CONTROL
`define MFHI_CONTROL  5'b10100
`endif
`ifndef MFLO_CONTROL
`define MFLO_CONTROL  5'b10101
`endif

interface hilo_mdu_if;
    logic [4:0]  alucontrol;
    logic        ex_valid;
    logic        ex_adv;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        mdu_stall;
    logic [31:0] hilo_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: presents the EX instruction, observes stall and HI/LO.
    modport master (
        output alucontrol, ex_valid, ex_adv, flush, a, b,
        input  mdu_stall, hilo_rdata, hi, lo
    );

    // Multiply unit side.
    modport slave (
        input  alucontrol, ex_valid, ex_adv, flush, a, b,
        output mdu_stall, hilo_rdata, hi, lo
    );
endinterface

// File: rtl/hilo_mdu.sv
// Iterative 32x32 multiply unit with the architectural HI/LO pair.
// Shift-and-add over 32 cycles on operand magnitudes; the sign is applied
// to the 64-bit result when it is written to HI/LO.
module hilo_mdu (
    input  logic      clk,
    input  logic      resetn,
    hilo_mdu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] mcand;
    logic [31:0] mb;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic        neg;

    logic        is_signed;
    logic        is_mul;
    logic        ex_commit;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] acc_sum;
    logic [63:0] acc_neg;

    // Decode, operand magnitudes and the next partial sum.
    always_comb begin
        is_signed = (bus.alucontrol == `MULT_CONTROL);
        is_mul    = bus.ex_valid & ~bus.flush &
                    (is_signed | (bus.alucontrol == `MULTU_CONTROL));
        ex_commit = bus.ex_valid & bus.ex_adv & ~bus.flush;
        // 0x80000000 negates to itself, which is its correct unsigned magnitude.
        a_mag     = (is_signed & bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        b_mag     = (is_signed & bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
        // mcand is kept pre-shifted, so it always equals {32'b0,ma} << cnt.
        acc_sum   = acc + (mb[0] ? mcand : '0);
        acc_neg   = ~acc_sum + 64'd1;
    end

    // Sequencer, multiply datapath and HI/LO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
            mcand <= '0;
            mb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        mcand <= {32'b0, a_mag};
                        mb    <= b_mag;
                        neg   <= is_signed & (bus.a[31] ^ bus.b[31]);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end else if (ex_commit) begin
                        if (bus.alucontrol == `MTHI_CONTROL) hi_q <= bus.a;
                        if (bus.alucontrol == `MTLO_CONTROL) lo_q <= bus.a;
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc_sum;
                        mcand <= mcand << 1;
                        mb    <= mb >> 1;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            {hi_q, lo_q} <= neg ? acc_neg : acc_sum;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.flush || bus.ex_adv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall and read-data outputs; stall is forced low while reset is held.
    always_comb begin
        bus.mdu_stall = resetn & (((state == IDLE) & is_mul) | (state == BUSY));
        if (bus.alucontrol == `MFHI_CONTROL)
            bus.hilo_rdata = hi_q;
        else if (bus.alucontrol == `MFLO_CONTROL)
            bus.hilo_rdata = lo_q;
        else
            bus.hilo_rdata = '0;
        bus.hi = hi_q;
        bus.lo = lo_q;
    end

endmodule
